dma_responder: RTL

DMA_RESPONDER -- requirements
Module: dma_responder

---
 rtl/dma_pkg.sv | 6 +
 rtl/dma_wait_timer.sv | 19 +
 rtl/dma_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding and parameter defaults for the DMA responder.
package dma_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_GRANT, ST_ACCESS, ST_ACK, ST_RELEASE} dma_state_e;
    localparam logic [7:0] MEM_WAIT_DEF = 8'd64;
    localparam int BURST_MAX_DEF = 16;
endpackage

// File: rtl/dma_wait_timer.sv
// dma_wait_timer: loadable down-counter that flags the cycle its count runs out.
module dma_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    // Asserted while the final counted cycle is being decremented away.
    assign zero_o = dec_i && cnt_q <= W'(1);
endmodule

// File: rtl/dma_responder.sv
// dma_responder: bridges a DMA master onto the host bus and memory with ack timeout.
// Define DMA_RESP_BURST_LIMIT_EN to release the grant after BURST_MAX acks.
module dma_responder import dma_pkg::*; #(
    parameter logic [7:0] MEM_WAIT  = MEM_WAIT_DEF,
    parameter int         BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dma_req_i,
    output logic        dma_gnt_o,
    input  logic [21:0] dma_adr_i,
    input  logic [15:0] dma_dat_i,
    output logic [15:0] dma_dat_o,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    output logic        dma_ack_o,
    output logic        hst_req_o,
    input  logic        hst_gnt_i,
    output logic [21:0] mem_adr_o,
    output logic [15:0] mem_dat_o,
    input  logic [15:0] mem_dat_i,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    input  logic        mem_ack_i,
    output logic        err_o
);
    dma_state_e  state_q, state_d;
    logic [20:0] adr_q;
    logic        abort_q, tmr_zero, acked, start, burst_done, unused_adr;

    assign unused_adr = dma_adr_i[0];
    assign acked      = state_q == ST_ACCESS && mem_ack_i && dma_stb_i && !abort_q;
    assign start      = state_q == ST_GRANT && state_d == ST_ACCESS;
    assign hst_req_o  = state_q inside {ST_ARB, ST_GRANT, ST_ACCESS, ST_ACK};
    assign dma_gnt_o  = state_q inside {ST_GRANT, ST_ACCESS, ST_ACK};
    assign dma_ack_o  = state_q == ST_ACK;
    assign mem_stb_o  = state_q == ST_ACCESS;
    assign mem_adr_o  = {adr_q, 1'b0};

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= ST_IDLE;
        else state_q <= state_d;

    // A lost host grant only takes effect once the transfer in flight has finished.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = dma_req_i ? ST_ARB : ST_IDLE;
            ST_ARB:    state_d = hst_gnt_i ? ST_GRANT : !dma_req_i ? ST_RELEASE : ST_ARB;
            ST_GRANT:  state_d = !hst_gnt_i ? ST_RELEASE : dma_stb_i ? ST_ACCESS :
                                 !dma_req_i ? ST_RELEASE : ST_GRANT;
            ST_ACCESS: state_d = acked ? ST_ACK : (mem_ack_i || tmr_zero) ?
                                 (hst_gnt_i ? ST_GRANT : ST_RELEASE) : ST_ACCESS;
            ST_ACK:    state_d = dma_stb_i ? ST_ACK :
                                 (hst_gnt_i && !burst_done) ? ST_GRANT : ST_RELEASE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            adr_q     <= '0;
            mem_dat_o <= '0;
            mem_we_o  <= 1'b0;
            dma_dat_o <= '0;
            err_o     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            err_o   <= state_q == ST_ACCESS && !mem_ack_i && tmr_zero;
            abort_q <= start ? 1'b0 : abort_q || (state_q == ST_ACCESS && !dma_stb_i);
            if (start) begin
                adr_q     <= dma_adr_i[21:1];
                mem_dat_o <= dma_dat_i;
                mem_we_o  <= dma_we_i;
            end
            if (state_q == ST_ACCESS && mem_ack_i && !mem_we_o) dma_dat_o <= mem_dat_i;
        end

    dma_wait_timer #(.W(8)) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(start),
        .dec_i (state_q == ST_ACCESS),
        .val_i (MEM_WAIT),
        .zero_o(tmr_zero)
    );

`ifdef DMA_RESP_BURST_LIMIT_EN
    localparam int BW = $clog2(BURST_MAX + 1);
    logic [BW-1:0] burst_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) burst_q <= '0;
        else if (state_q == ST_RELEASE) burst_q <= '0;
        else if (acked) burst_q <= burst_q + 1'b1;
    assign burst_done = burst_q == BW'(BURST_MAX);
`else
    localparam int unused_burst_max = BURST_MAX;
    assign burst_done = 1'b0;
`endif
endmodule
